// File: rtl/fp32_mul_arbiter_if.sv
// Request/response channels between the core issue logic (master) and the
// shared fp32 multiplier arbiter (slave).
interface fp32_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_z;
  logic                  resp_timeout;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_z, resp_timeout
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_z, resp_timeout
  );
endinterface

// File: rtl/fp32_mul_arbiter.sv
// Round-robin arbiter time-sharing one fp32 multiplier among NUM_REQ requesters;
// a watchdog turns a missing mul_done into a qNaN timeout response.
//
// state | meaning
// IDLE  | pick next requester round-robin, pulse req_ready, latch operands
// LOAD  | one-cycle mul_start pulse; a stale mul_done is ignored here
// WAIT  | wait for mul_done or watchdog expiry
// RESP  | hold response until resp_ready
module fp32_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  fp32_mul_arbiter_if.slave bus,
  output logic              busy,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  output logic              mul_start,
  input  logic [31:0]       mul_z,
  input  logic              mul_done
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q;
  logic [ID_W-1:0] last_grant_q;
  logic [ID_W-1:0] id_q;
  logic [7:0]      cnt_q;
  logic [7:0]      cnt_d;
  logic [31:0]     mul_a_q;
  logic [31:0]     mul_b_q;
  logic            mul_start_q;
  logic            busy_q;
  logic            resp_valid_q;
  logic [ID_W-1:0] resp_id_q;
  logic [31:0]     resp_z_q;
  logic            resp_timeout_q;

  logic [31:0]     op_a [NUM_REQ];
  logic [31:0]     op_b [NUM_REQ];
  logic            any_valid;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] scan_idx;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign op_a[k] = bus.req_a[32*k +: 32];
    assign op_b[k] = bus.req_b[32*k +: 32];
  end

  // Scan from farthest to nearest so the nearest valid after last_grant wins.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = ID_W'((32'(last_grant_q) + 32'(k)) % 32'(NUM_REQ));
      if (bus.req_valid[scan_idx]) begin
        any_valid = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == S_IDLE && any_valid && !rst) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  assign cnt_d = cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      last_grant_q   <= ID_W'(NUM_REQ - 1);
      id_q           <= '0;
      cnt_q          <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      mul_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_z_q       <= '0;
      resp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            mul_a_q      <= op_a[grant_idx];
            mul_b_q      <= op_b[grant_idx];
            id_q         <= grant_idx;
            last_grant_q <= grant_idx;
            mul_start_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          mul_start_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          // done takes priority over a watchdog expiry in the same cycle
          if (mul_done) begin
            resp_z_q       <= mul_z;
            resp_timeout_q <= 1'b0;
            resp_id_q      <= id_q;
            resp_valid_q   <= 1'b1;
            state_q        <= S_RESP;
          end else if (cnt_d == 8'(TIMEOUT)) begin
            resp_z_q       <= QNAN;
            resp_timeout_q <= 1'b1;
            resp_id_q      <= id_q;
            resp_valid_q   <= 1'b1;
            state_q        <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_z       = resp_z_q;
  assign bus.resp_timeout = resp_timeout_q;
  assign busy             = busy_q;
  assign mul_a            = mul_a_q;
  assign mul_b            = mul_b_q;
  assign mul_start        = mul_start_q;

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Bench for fp32_mul_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of grants, multiplier timing and responses.
module tb_fp32_mul_arbiter;

  localparam int          NUM_REQ = 4;
  localparam int          ID_W    = 2;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam int          QDEPTH  = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic        mul_start;
  logic        mul_done;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_z;

  fp32_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  fp32_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_start(mul_start),
    .mul_z    (mul_z),
    .mul_done (mul_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Stand-in product: a few real fp32 results, otherwise an arbitrary bit mix.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4000_0000;
    if (a == 32'h4040_0000 && b == 32'h4040_0000) return 32'h4110_0000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h0123_4567;
  endfunction

  // Per-requester operation queues; lat = cycles from mul_start to done, 0 = never.
  logic [31:0] qa [NUM_REQ][QDEPTH];
  logic [31:0] qb [NUM_REQ][QDEPTH];
  int          ql [NUM_REQ][QDEPTH];
  int          head [NUM_REQ];
  int          tail [NUM_REQ];
  int          rr_mode = 1;   // 0 random, 1 always ready, 2 stalled

  task automatic push(input int r, input logic [31:0] a, input logic [31:0] b, input int lat);
    if (tail[r] >= QDEPTH) $fatal(1, "queue overflow");
    qa[r][tail[r]] = a;
    qb[r][tail[r]] = b;
    ql[r][tail[r]] = lat;
    tail[r]++;
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head[i] < tail[i]) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_a[32*i +: 32]   = qa[i][head[i]];
        bus.req_b[32*i +: 32]   = qb[i][head[i]];
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_a[32*i +: 32]   = $urandom;
        bus.req_b[32*i +: 32]   = $urandom;
      end
    end
    case (rr_mode)
      0:       bus.resp_ready = ($urandom_range(0, 3) != 0);
      1:       bus.resp_ready = 1'b1;
      default: bus.resp_ready = 1'b0;
    endcase
  end

  // Multiplier stand-in; its done stays high until the next start pulse.
  int          cur_lat = 1;
  int          mcnt    = 0;
  logic        mdone   = 1'b0;
  logic [31:0] mres    = '0;

  always @(posedge clk) begin
    if (mul_start) begin
      mres  <= fmul(mul_a, mul_b);
      mdone <= (cur_lat == 1);
      mcnt  <= (cur_lat > 1) ? cur_lat - 1 : 0;
    end else if (mcnt == 1) begin
      mdone <= 1'b1;
      mcnt  <= 0;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end
  end

  assign mul_done = mdone;
  assign mul_z    = mdone ? mres : 32'hDEAD_BEEF;

  // Reference model state and logs
  int          ptr = NUM_REQ - 1;
  bit          inflight = 0;
  bit          resp_pend = 0;
  int          t_start = -1;
  int          t_resp = -1;
  int          c_id, c_lat;
  logic [31:0] c_a, c_b, e_z;
  bit          e_to;
  int          resp_cnt = 0;
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          rise_cyc = 0;
  bit          rv_prev = 0;
  int          grant_ids[$];
  int          grant_cyc[$];
  int          hs_cyc[$];
  int          rid_log[$];
  logic [31:0] rz_log[$];
  bit          rto_log[$];

  logic [NUM_REQ-1:0] er;
  int                 g;
  bit                 busy_e;

  always @(negedge clk) begin
    if (mul_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (bus.resp_valid && !rv_prev) rise_cyc = cyc;
    rv_prev = bus.resp_valid;

    if (rst) begin
      chk("req_ready_in_reset", bus.req_ready, '0);
      ptr       = NUM_REQ - 1;
      inflight  = 0;
      resp_pend = 0;
      t_start   = -1;
      t_resp    = -1;
    end else begin
      busy_e = inflight;
      er = '0;
      g  = -1;
      if (!inflight) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (g < 0 && bus.req_valid[(ptr + k) % NUM_REQ]) g = (ptr + k) % NUM_REQ;
        end
      end
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", bus.req_ready, er);
      if (g >= 0) begin
        inflight = 1;
        ptr      = g;
        c_id     = g;
        c_a      = bus.req_a[32*g +: 32];
        c_b      = bus.req_b[32*g +: 32];
        c_lat    = ql[g][head[g]];
        cur_lat  = c_lat;
        head[g]++;
        t_start  = cyc + 1;
        t_resp   = -1;
        grant_ids.push_back(g);
        grant_cyc.push_back(cyc);
      end

      chk("mul_start", mul_start, (cyc == t_start));
      if (cyc == t_start) begin
        e_to   = (c_lat == 0 || c_lat > TIMEOUT);
        t_resp = cyc + (e_to ? TIMEOUT : c_lat) + 1;
        e_z    = e_to ? QNAN : fmul(c_a, c_b);
      end
      if (inflight && t_start >= 0 && cyc >= t_start && cyc < t_resp) begin
        chk("mul_a", mul_a, c_a);
        chk("mul_b", mul_b, c_b);
      end

      if (cyc == t_resp) resp_pend = 1;
      chk("resp_valid", bus.resp_valid, resp_pend);
      chk("busy", busy, busy_e);
      if (resp_pend) begin
        chk("resp_id", bus.resp_id, c_id);
        chk("resp_z", bus.resp_z, e_z);
        chk("resp_timeout", bus.resp_timeout, e_to);
        if (bus.resp_ready) begin
          resp_pend = 0;
          inflight  = 0;
          hs_cyc.push_back(cyc);
          rid_log.push_back(c_id);
          rz_log.push_back(e_z);
          rto_log.push_back(e_to);
          resp_cnt++;
        end
      end
    end
  end

  task automatic wait_resps(input int n, input int budget);
    int w;
    w = 0;
    while (resp_cnt < n && w < budget) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("resp_count", resp_cnt, n);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  int base, gb, sb, w, gc;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_id", bus.resp_id, 0);
    chk("rst_resp_z", bus.resp_z, 0);
    chk("rst_resp_timeout", bus.resp_timeout, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);

    // T1 single
    base = resp_cnt; sb = start_cnt;
    push(0, 32'h3F80_0000, 32'h4000_0000, 3);
    wait_resps(base + 1, 200);
    chk("t1_starts", start_cnt - sb, 1);
    chk("t1_z", rz_log[base], 32'h4000_0000);
    chk("t1_id", rid_log[base], 0);
    chk("t1_to", rto_log[base], 0);

    // T2 round-robin from reset
    pulse_reset();
    @(negedge clk);
    base = resp_cnt; gb = grant_ids.size();
    for (int i = 0; i < NUM_REQ; i++) push(i, 32'h4000_0000 + i, 32'h3F00_0000 + 7 * i, 2);
    push(0, 32'h4100_0000, 32'h4200_0000, 2);
    wait_resps(base + 5, 400);
    for (int k = 0; k < 5; k++) begin
      chk("t2_grant_order", grant_ids[gb + k], exp_order[k]);
      chk("t2_resp_order", rid_log[base + k], exp_order[k]);
    end

    // T3 back-pressure
    rr_mode = 2;
    base = resp_cnt; gb = grant_ids.size();
    @(negedge clk);
    push(0, 32'h1111_1111, 32'h2222_2222, 2);
    w = 0;
    while (!bus.resp_valid && w < 100) begin
      @(posedge clk);
      #1 w++;
    end
    chk("t3_resp_seen", bus.resp_valid, 1);
    @(negedge clk);
    push(1, 32'h3333_3333, 32'h4444_4444, 2);
    gc = grant_ids.size();
    repeat (20) @(posedge clk);
    #1;
    chk("t3_no_grant_while_stalled", grant_ids.size(), gc);
    chk("t3_still_valid", bus.resp_valid, 1);
    rr_mode = 1;
    wait_resps(base + 2, 200);
    chk("t3_first", grant_ids[gb], 0);
    chk("t3_second", grant_ids[gb + 1], 1);
    chk("t3_regrant_gap", grant_cyc[gb + 1] - hs_cyc[base], 1);

    // T4 timeout
    base = resp_cnt;
    @(negedge clk);
    push(2, 32'h5555_5555, 32'h6666_6666, 0);
    wait_resps(base + 1, 200);
    chk("t4_z", rz_log[base], QNAN);
    chk("t4_to", rto_log[base], 1);
    chk("t4_latency", rise_cyc - start_cyc, TIMEOUT + 1);

    // T5 stale done across LOAD
    base = resp_cnt;
    @(negedge clk);
    push(3, 32'h7777_7777, 32'h0000_1234, 1);
    push(0, 32'h4040_0000, 32'h4040_0000, 4);
    wait_resps(base + 2, 200);
    chk("t5_z", rz_log[base + 1], 32'h4110_0000);
    chk("t5_to", rto_log[base + 1], 0);
    chk("t5_latency", rise_cyc - start_cyc, 5);

    // T6 reset in WAIT after granting requester 2
    base = resp_cnt; gc = grant_ids.size();
    @(negedge clk);
    push(2, 32'h0BAD_F00D, 32'h0000_0001, 0);
    w = 0;
    while (grant_ids.size() == gc && w < 50) begin
      @(posedge clk);
      w++;
    end
    chk("t6_granted", grant_ids.size(), gc + 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("t6_no_resp", resp_cnt, base);
    @(negedge clk);
    gb = grant_ids.size();
    push(3, 32'h0000_0033, 32'h0000_0044, 2);
    push(0, 32'h0000_0011, 32'h0000_0022, 2);
    wait_resps(base + 2, 200);
    chk("t6_first_after_reset", grant_ids[gb], 0);
    chk("t6_second_after_reset", grant_ids[gb + 1], 3);

    // Randomized traffic with random back-pressure and boundary latencies
    rr_mode = 0;
    base = resp_cnt;
    for (int n = 0; n < 60; n++) begin
      int r, sel, lat;
      @(negedge clk);
      r   = $urandom_range(0, NUM_REQ - 1);
      sel = $urandom_range(0, 9);
      case (sel)
        0:       lat = 0;
        1:       lat = TIMEOUT;
        2:       lat = TIMEOUT + 1;
        3:       lat = TIMEOUT - 1;
        default: lat = $urandom_range(1, 6);
      endcase
      push(r, $urandom, $urandom, lat);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    wait_resps(base + 60, 5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
